// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or3_evtsync_if.sv
// Event/request interface for the OR3 event synchronizer.
//   A1, A2, A3 : asynchronous event sources (producer side)
//   ACK        : consumer acknowledge, synchronous to the block clock
//   Z          : registered level request, held until acknowledged
//   ZP         : registered one-cycle pulse marking request entry
//   SRC        : registered sticky source bits {A3,A2,A1}
// master: the environment that drives the sources and acknowledges.
// slave : the synchronizer itself.
interface gf180mcu_fd_sc_mcu9t5v0__or3_evtsync_if;
  logic       A1;
  logic       A2;
  logic       A3;
  logic       ACK;
  logic       Z;
  logic       ZP;
  logic [2:0] SRC;

  modport master (
    output A1,
    output A2,
    output A3,
    output ACK,
    input  Z,
    input  ZP,
    input  SRC
  );

  modport slave (
    input  A1,
    input  A2,
    input  A3,
    input  ACK,
    output Z,
    output ZP,
    output SRC
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or3_evtsync.sv
// OR3 event synchronizer with debounce filter and acknowledge handshake.
//
// Three asynchronous event sources are each brought into the CLK domain through
// a 2-flop synchronizer. The OR of the synchronized bits must be seen high for
// DBNC consecutive samples before a request is raised on Z. The request stays up
// until the consumer acknowledges it; afterwards the block waits for all
// sources to go quiet before it can trigger again, so a stuck source produces
// exactly one request.
//
// Ports:
//   CLK : single clock, all flops rising-edge
//   RN  : asynchronous active-low reset
//   bus : slave side of the event interface (A1..A3, ACK in; Z, ZP, SRC out)
//
// Parameter:
//   DBNC : consecutive high samples needed to raise Z, legal range 1..15
module gf180mcu_fd_sc_mcu9t5v0__or3_evtsync #(
  parameter int unsigned DBNC = 4
) (
  input logic                                      CLK,
  input logic                                      RN,
  gf180mcu_fd_sc_mcu9t5v0__or3_evtsync_if.slave    bus
);

  localparam logic [3:0] DbncCnt = 4'(DBNC);

  typedef enum logic [1:0] {
    StIdle,
    StFilter,
    StActive,
    StRearm
  } state_e;

  // Synchronizer stages, bit order {A3,A2,A1}.
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic [2:0] raw;
  logic       s;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] count_inc;
  logic       z_q, z_d;
  logic       zp_q, zp_d;
  logic [2:0] src_q, src_d;

  assign raw       = {bus.A3, bus.A2, bus.A1};
  assign s         = |sync_q;
  assign count_inc = count_q + 4'd1;

  // Next-state logic. Outputs are computed alongside the state so that Z, ZP
  // and SRC come straight from flops with no path from any input.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    z_d     = z_q;
    zp_d    = 1'b0;
    src_d   = src_q;

    unique case (state_q)
      StIdle: begin
        if (s) begin
          if (DbncCnt == 4'd1) begin
            state_d = StActive;
            z_d     = 1'b1;
            zp_d    = 1'b1;
            src_d   = sync_q;
          end else begin
            state_d = StFilter;
            count_d = 4'd1;
          end
        end
      end

      StFilter: begin
        if (!s) begin
          state_d = StIdle;
          count_d = 4'd0;
        end else if (count_inc == DbncCnt) begin
          // Sources that joined during filtering are captured here.
          state_d = StActive;
          count_d = 4'd0;
          z_d     = 1'b1;
          zp_d    = 1'b1;
          src_d   = sync_q;
        end else begin
          count_d = count_inc;
        end
      end

      StActive: begin
        if (bus.ACK) begin
          state_d = StRearm;
          z_d     = 1'b0;
          src_d   = 3'b000;
        end else begin
          src_d = src_q | sync_q;
        end
      end

      StRearm: begin
        // Wait for every source to drop so a held source cannot retrigger.
        if (!s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        count_d = 4'd0;
        z_d     = 1'b0;
        src_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      meta_q  <= 3'b000;
      sync_q  <= 3'b000;
      state_q <= StIdle;
      count_q <= 4'd0;
      z_q     <= 1'b0;
      zp_q    <= 1'b0;
      src_q   <= 3'b000;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      state_q <= state_d;
      count_q <= count_d;
      z_q     <= z_d;
      zp_q    <= zp_d;
      src_q   <= src_d;
    end
  end

  assign bus.Z   = z_q;
  assign bus.ZP  = zp_q;
  assign bus.SRC = src_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__or3_evtsync.md
GF180MCU_FD_SC_MCU9T5V0__OR3_EVTSYNC -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__or3_evtsync

Interface
REQ-001 The block SHALL have parameter DBNC, default 4, meaning consecutive high samples of the synchronized OR3 term needed to raise Z; legal range 1..15.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all flops rising-edge.
REQ-003 The block SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports A1, A2, A3  input  1 each  asynchronous event sources.
REQ-005 The block SHALL have port ACK  input  1  consumer acknowledge, synchronous to CLK.
REQ-006 The block SHALL have port Z  output  1  registered level request, asserted until acknowledged.
REQ-007 The block SHALL have port ZP  output  1  registered one-cycle pulse marking request entry.
REQ-008 The block SHALL have port SRC  output  3  registered sticky source bits {A3,A2,A1}.

Function
REQ-009 Each Ai SHALL pass through its own 2-flop synchronizer; the synchronized bits are s1, s2, s3, and s = s1|s2|s3.
REQ-010 The FSM SHALL have exactly four states: IDLE, FILTER, ACTIVE, REARM.
REQ-011 In IDLE, s=1: DBNC=1 -> ACTIVE; otherwise -> FILTER with count=1. In IDLE, s=0: stay.
REQ-012 In FILTER, s=0 -> IDLE with count cleared; s=1 and count+1==DBNC -> ACTIVE; s=1 otherwise -> count+1.
REQ-013 The count register SHALL be 4 bits wide and never wrap; it is only written in IDLE or FILTER.
REQ-014 Z SHALL be 1 exactly while the state is ACTIVE and 0 in all other states, driven from a flop with no combinational path from any input.
REQ-015 ZP SHALL be 1 for exactly one cycle, the cycle immediately after the edge that enters ACTIVE.
REQ-016 At the edge entering ACTIVE, SRC SHALL load {s3,s2,s1}.
REQ-017 On each edge while in ACTIVE, SRC SHALL OR in {s3,s2,s1}.
REQ-018 ACK SHALL be honoured only when the state is ACTIVE; ACK in any other state, including the entry edge itself, SHALL be ignored.
REQ-019 ACK=1 in ACTIVE SHALL move the FSM to REARM; at that same edge Z->0 and SRC->000.
REQ-020 In REARM, s=0 -> IDLE; s=1 -> stay in REARM, so a held source never retriggers.
REQ-021 Latency: a source rising before edge 0 and held high SHALL produce Z=1 after edge DBNC+1, i.e. the (DBNC+2)th sampling edge.
REQ-022 Simultaneous sources SHALL all appear in SRC; a source arriving while in FILTER is included at entry.

Reset
REQ-023 RN=0 SHALL immediately force, regardless of CLK, all of the following: synchronizer flops 0, state IDLE, count 0, Z=0, ZP=0, SRC=000.
REQ-024 Reset SHALL take effect from any state, including mid-FILTER and ACTIVE, with no pulse emitted.
REQ-025 After RN deasserts, the FSM SHALL begin sampling at the first CLK rising edge; RN deassertion timing is the integrator's responsibility.

Verification
REQ-026 Held trigger: DBNC=4, A2 rises before edge 0 and is held -> Z=1 after edge 5, ZP=1 only between edges 5 and 6, SRC=010.
REQ-027 Glitch reject: DBNC=4, A1 high for exactly 3 cycles -> Z, ZP and SRC stay 0; FSM returns to IDLE.
REQ-028 Stuck source: ACK pulse while A3 held high -> Z=0, SRC=000, no retrigger; A3 low for at least 3 cycles then high again -> a new request with SRC=100.
REQ-029 Source accumulation: A1 and A3 rise together -> SRC=101 at entry; A2 rises during ACTIVE -> SRC=111 three edges later.
REQ-030 Reset and stray acknowledge: RN pulsed low mid-ACTIVE -> Z=0, SRC=000 asynchronously; ACK asserted in IDLE and in FILTER -> no effect.
REQ-031 Minimum filter: DBNC=1, A1 held high -> Z=1 after edge 2.
